// File: rtl/msf_sync_controller.sv
// MSF time sync controller: acquires decoded hh:mm frames, confirms them against
// a candidate one minute later, then tracks a BCD hh:mm:ss display from the
// radio seconds, falling back to the local 1 Hz tick when the signal degrades.
module msf_sync_controller #(
  parameter int SILENCE_S    = 3,
  parameter int MAX_MISS     = 5,
  parameter int CONFIRM_TO_S = 62
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic       dec_valid_i,
  input  logic [1:0] dec_hour_h_i,
  input  logic [3:0] dec_hour_l_i,
  input  logic [2:0] dec_minute_h_i,
  input  logic [3:0] dec_minute_l_i,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic [1:0] state_o,
  output logic       synced_o,
  output logic       load_o
);

  localparam int TW = $clog2(CONFIRM_TO_S + 1);
  localparam int SW = $clog2(SILENCE_S + 1);
  localparam int MW = $clog2(MAX_MISS + 1);

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_CONF = 2'd1,
    ST_SYNC = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] hh_h;
    logic [3:0] hh_l;
    logic [2:0] mm_h;
    logic [3:0] mm_l;
  } hm_t;

  state_t        state_q, state_n;
  hm_t           hm_q, hm_n, cand_q, cand_n, dec, exp_hm;
  logic [2:0]    ss_h_q, ss_h_n;
  logic [3:0]    ss_l_q, ss_l_n;
  logic [TW-1:0] to_q, to_n;
  logic [SW-1:0] sil_q, sil_n;
  logic [MW-1:0] miss_q, miss_n;
  logic          load_q, load_n;
  logic          frame_evt, in_range, good, adv;

  // hh:mm plus one minute with BCD carries and midnight wrap
  function automatic hm_t inc1m(input hm_t t);
    hm_t r;
    r = t;
    if (t.mm_l != 4'd9) r.mm_l = t.mm_l + 4'd1;
    else begin
      r.mm_l = 4'd0;
      if (t.mm_h != 3'd5) r.mm_h = t.mm_h + 3'd1;
      else begin
        r.mm_h = 3'd0;
        if (t.hh_h == 2'd2 && t.hh_l == 4'd3) begin
          r.hh_h = 2'd0;
          r.hh_l = 4'd0;
        end else if (t.hh_l == 4'd9) begin
          r.hh_l = 4'd0;
          r.hh_h = t.hh_h + 2'd1;
        end else r.hh_l = t.hh_l + 4'd1;
      end
    end
    return r;
  endfunction

  assign dec       = {dec_hour_h_i, dec_hour_l_i, dec_minute_h_i, dec_minute_l_i};
  assign frame_evt = bits_valid_i & bits_is_second_00_i;
  assign in_range  = (dec.hh_h <= 2'd2) && (dec.hh_l <= 4'd9) &&
                     !(dec.hh_h == 2'd2 && dec.hh_l > 4'd3) &&
                     (dec.mm_h <= 3'd5) && (dec.mm_l <= 4'd9);
  assign good      = frame_evt & dec_valid_i & in_range;
  // in holdover, a frame after the half minute is expected to name the next minute
  assign exp_hm    = (ss_h_q >= 3'd3) ? inc1m(hm_q) : hm_q;

  // next-state, watchdogs and display update; load beats advance
  always_comb begin
    state_n = state_q;
    hm_n    = hm_q;
    ss_h_n  = ss_h_q;
    ss_l_n  = ss_l_q;
    cand_n  = cand_q;
    to_n    = to_q;
    sil_n   = sil_q;
    miss_n  = miss_q;
    load_n  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ST_ACQ: begin
        adv = tick_1hz_i;
        if (good) begin
          cand_n  = dec;
          to_n    = '0;
          state_n = ST_CONF;
        end
      end
      ST_CONF: begin
        adv = tick_1hz_i;
        if (frame_evt) begin
          if (good && dec == inc1m(cand_q)) begin
            load_n  = 1'b1;
            miss_n  = '0;
            sil_n   = '0;
            state_n = ST_SYNC;
          end else if (good) begin
            cand_n = dec;
            to_n   = '0;
          end else state_n = ST_ACQ;
        end else if (tick_1hz_i) begin
          to_n = to_q + TW'(1);
          if (to_n == TW'(CONFIRM_TO_S)) state_n = ST_ACQ;
        end
      end
      ST_SYNC: begin
        adv = bits_valid_i & ~frame_evt;
        if (bits_valid_i) sil_n = '0;
        else if (tick_1hz_i) begin
          sil_n = sil_q + SW'(1);
          if (sil_n == SW'(SILENCE_S)) state_n = ST_HOLD;
        end
        if (frame_evt) begin
          if (good) begin
            load_n = 1'b1;
            miss_n = '0;
          end else begin
            // missed frame: assume a minute passed and realign seconds
            hm_n   = inc1m(hm_q);
            ss_h_n = 3'd0;
            ss_l_n = 4'd0;
            if (miss_q != MW'(MAX_MISS)) miss_n = miss_q + MW'(1);
            if (miss_n == MW'(MAX_MISS)) state_n = ST_HOLD;
          end
        end
      end
      default: begin
        adv = tick_1hz_i;
        if (good) begin
          if (dec == exp_hm) begin
            load_n  = 1'b1;
            miss_n  = '0;
            sil_n   = '0;
            state_n = ST_SYNC;
          end else begin
            cand_n  = dec;
            to_n    = '0;
            state_n = ST_CONF;
          end
        end
      end
    endcase
    if (load_n) begin
      hm_n   = dec;
      ss_h_n = 3'd0;
      ss_l_n = 4'd0;
    end else if (adv) begin
      if (ss_l_q != 4'd9) ss_l_n = ss_l_q + 4'd1;
      else begin
        ss_l_n = 4'd0;
        if (ss_h_q != 3'd5) ss_h_n = ss_h_q + 3'd1;
        else begin
          ss_h_n = 3'd0;
          hm_n   = inc1m(hm_q);
        end
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACQ;
      hm_q    <= '0;
      ss_h_q  <= '0;
      ss_l_q  <= '0;
      cand_q  <= '0;
      to_q    <= '0;
      sil_q   <= '0;
      miss_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hm_q    <= hm_n;
      ss_h_q  <= ss_h_n;
      ss_l_q  <= ss_l_n;
      cand_q  <= cand_n;
      to_q    <= to_n;
      sil_q   <= sil_n;
      miss_q  <= miss_n;
      load_q  <= load_n;
    end
  end

  assign hour_h_o   = hm_q.hh_h;
  assign hour_l_o   = hm_q.hh_l;
  assign minute_h_o = hm_q.mm_h;
  assign minute_l_o = hm_q.mm_l;
  assign second_h_o = ss_h_q;
  assign second_l_o = ss_l_q;
  assign state_o    = state_q;
  assign synced_o   = (state_q == ST_SYNC);
  assign load_o     = load_q;

endmodule

// File: tb/tb_msf_sync_controller.sv
// Directed bench for msf_sync_controller; display compared as hex hhmmss.
module tb_msf_sync_controller;
  logic       clk = 1'b0;
  logic       rst, tick, bv, s00, dv;
  logic [1:0] dhh_h;
  logic [3:0] dhh_l;
  logic [2:0] dmm_h;
  logic [3:0] dmm_l;
  logic [1:0] hour_h, state;
  logic [3:0] hour_l, minute_l, second_l;
  logic [2:0] minute_h, second_h;
  logic       synced, load;
  logic [23:0] disp;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  msf_sync_controller dut (
    .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick), .bits_valid_i(bv),
    .bits_is_second_00_i(s00), .dec_valid_i(dv),
    .dec_hour_h_i(dhh_h), .dec_hour_l_i(dhh_l),
    .dec_minute_h_i(dmm_h), .dec_minute_l_i(dmm_l),
    .hour_h_o(hour_h), .hour_l_o(hour_l), .minute_h_o(minute_h),
    .minute_l_o(minute_l), .second_h_o(second_h), .second_l_o(second_l),
    .state_o(state), .synced_o(synced), .load_o(load)
  );

  assign disp = {2'b00, hour_h, hour_l, 1'b0, minute_h, minute_l,
                 1'b0, second_h, second_l};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      bv = 1'b1;
      cyc();
      bv = 1'b0;
    end
  endtask

  task automatic frame(input logic v, input logic [7:0] hh, input logic [7:0] mm);
    bv = 1'b1; s00 = 1'b1; dv = v;
    dhh_h = hh[5:4]; dhh_l = hh[3:0]; dmm_h = mm[6:4]; dmm_l = mm[3:0];
    cyc();
    bv = 1'b0; s00 = 1'b0; dv = 1'b0;
  endtask

  task automatic reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; bv = 1'b0; s00 = 1'b0; dv = 1'b0;
    dhh_h = '0; dhh_l = '0; dmm_h = '0; dmm_l = '0;

    // 1: reset state and free-running ticks
    reset();
    chk("rst_disp", disp, 24'h000000);
    chk("rst_state", state, 0);
    chk("rst_synced", synced, 0);
    chk("rst_load", load, 0);
    ticks(3);
    chk("tick3_disp", disp, 24'h000003);

    // 2: acquire then confirm one minute later
    frame(1'b1, 8'h12, 8'h34);
    chk("acq_state", state, 1);
    chk("acq_load", load, 0);
    ticks(60);
    chk("conf_run_disp", disp, 24'h000103);
    frame(1'b1, 8'h12, 8'h35);
    chk("conf_state", state, 2);
    chk("conf_disp", disp, 24'h123500);
    chk("conf_load", load, 1);
    cyc();
    chk("conf_load_drop", load, 0);
    chk("conf_synced", synced, 1);

    // 3: mismatched confirm re-arms candidate
    reset();
    frame(1'b1, 8'h12, 8'h34);
    frame(1'b1, 8'h12, 8'h40);
    chk("remis_state", state, 1);
    frame(1'b1, 8'h12, 8'h41);
    chk("recand_state", state, 2);
    chk("recand_disp", disp, 24'h124100);

    // 4: silence into holdover, then midnight rollover
    frame(1'b1, 8'h23, 8'h59);
    chk("sync_reload", disp, 24'h235900);
    secs(50);
    chk("sec50_disp", disp, 24'h235950);
    ticks(2);
    chk("sil2_state", state, 2);
    ticks(1);
    chk("sil3_state", state, 3);
    chk("sil3_disp", disp, 24'h235950);
    ticks(9);
    chk("hold_2359", disp, 24'h235959);
    ticks(1);
    chk("hold_wrap", disp, 24'h000000);

    // 5: holdover recovery, bad frame ignored, mismatch back to confirm
    reset();
    frame(1'b1, 8'h10, 8'h13);
    frame(1'b1, 8'h10, 8'h14);
    secs(45);
    ticks(3);
    chk("h5_state", state, 3);
    chk("h5_disp", disp, 24'h101445);
    frame(1'b1, 8'h10, 8'h15);
    chk("h5_resync_state", state, 2);
    chk("h5_resync_disp", disp, 24'h101500);
    chk("h5_resync_load", load, 1);
    secs(45);
    ticks(3);
    chk("h5b_state", state, 3);
    frame(1'b0, 8'h10, 8'h16);
    chk("h5b_bad_state", state, 3);
    chk("h5b_bad_disp", disp, 24'h101545);
    frame(1'b1, 8'h09, 8'h00);
    chk("h5b_mis_state", state, 1);
    chk("h5b_mis_disp", disp, 24'h101545);
    ticks(1);
    chk("h5b_run_disp", disp, 24'h101546);

    // 6: consecutive bad frames in sync, then reset mid-confirm
    frame(1'b1, 8'h09, 8'h01);
    chk("m6_sync", disp, 24'h090100);
    for (int i = 1; i <= 5; i++) begin
      frame(1'b0, 8'h00, 8'h00);
      chk($sformatf("miss%0d_disp", i), disp, 24'h090100 + (i << 8));
      chk($sformatf("miss%0d_state", i), state, (i == 5) ? 3 : 2);
    end
    frame(1'b1, 8'h07, 8'h00);
    chk("m6_conf", state, 1);
    reset();
    chk("m6_rst_state", state, 0);
    chk("m6_rst_disp", disp, 24'h000000);

    // confirm timeout boundary: 61 ticks stays, 62nd returns to acquire
    frame(1'b1, 8'h05, 8'h00);
    ticks(61);
    chk("to61_state", state, 1);
    ticks(1);
    chk("to62_state", state, 0);

    // out-of-range hour is not a good frame
    frame(1'b1, 8'h24, 8'h00);
    chk("range_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
